// File: rtl/connect4_pkg.sv
// Shared definitions for the Connect-4 board logic: player codes, cell
// indexing, the ten 4-in-a-row line masks and the win checker state encoding.
package connect4_pkg;

  localparam int BOARD_CELLS = 16;
  localparam int N_LINES     = 10;

  // Player codes, identical to the ColumnSelector state encoding
  localparam logic [1:0] P_NONE = 2'b00;
  localparam logic [1:0] P1     = 2'b01;
  localparam logic [1:0] P2     = 2'b10;

  // Bit position of cell (r, c); row 0 is the bottom row
  function automatic int idx(input int r, input int c);
    return r * 4 + c;
  endfunction

  // Scan order: rows 0-3, columns 0-3, diagonal, anti-diagonal.
  // The order matters: the lowest-index winning line is the one reported.
  localparam logic [15:0] LINE_MASK [0:N_LINES-1] = '{
    16'h000F, 16'h00F0, 16'h0F00, 16'hF000,
    16'h1111, 16'h2222, 16'h4444, 16'h8888,
    16'h8421, 16'h1248
  };

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SCAN   = 2'd1,
    RESULT = 2'd2
  } state_t;

endpackage

// File: rtl/win_checker_line_eval.sv
// Combinational evaluation of one candidate line: hit when all cells under
// the mask are occupied and share a single owner.
module line_eval
  import connect4_pkg::*;
(
  input  logic [15:0] board,
  input  logic [15:0] owners,
  input  logic [15:0] mask,
  output logic        hit,
  output logic [1:0]  owner
);

  logic full;
  logic all_p1;
  logic all_p2;

  // Occupancy and uniform-ownership tests over the masked cells
  always_comb begin
    full   = ((board & mask) == mask);
    all_p1 = ((owners & mask) == 16'h0000);
    all_p2 = ((owners & mask) == mask);
    hit    = full && (all_p1 || all_p2);
    owner  = all_p2 ? P2 : P1;
  end

endmodule

// File: rtl/win_checker.sv
// Connect-4 win checker. On a check request the board is snapshotted and the
// ten possible lines are scanned one per cycle; the first winning line stops
// the scan. A one-cycle done pulse marks a valid winner/draw result.
// Optional feature macro: WIN_LINE_EN -- when defined, win_line carries the
// mask of the winning cells; otherwise win_line is tied to zero.
module win_checker
  import connect4_pkg::*;
#(
  parameter int BOARD_N          = 4,
  parameter int STICKY_GAME_OVER = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        check,
  input  logic [15:0] gameboard,
  input  logic [15:0] players_cells,
  output logic        busy,
  output logic        done,
  output logic [1:0]  winner,
  output logic        draw,
  output logic        game_over,
  output logic [15:0] win_line
);

  localparam logic [3:0] LAST_IDX = 4'(N_LINES - 1);

  generate
    if (BOARD_N != 4) begin : g_bad_board
      $error("win_checker supports only BOARD_N = 4");
    end
  endgenerate

  state_t      state_reg;
  state_t      state_next;
  logic [3:0]  idx_reg;
  logic [15:0] snap_board_reg;
  logic [15:0] snap_owner_reg;
  logic [1:0]  winner_reg;
  logic        draw_reg;
  logic [15:0] cur_mask;
  logic        line_hit;
  logic [1:0]  line_owner;
  logic        start;
  logic        scan_last;

  // A request is accepted only from IDLE, and not after a finished game
  // when results are sticky
  always_comb begin
    start = (state_reg == IDLE) && check &&
            !((STICKY_GAME_OVER != 0) && game_over);
    scan_last = (idx_reg == LAST_IDX);
  end

  // Select the mask of the line under evaluation
  always_comb begin
    cur_mask = 16'h0000;
    for (int i = 0; i < N_LINES; i++) begin
      if (idx_reg == 4'(i)) cur_mask = LINE_MASK[i];
    end
  end

  line_eval u_line_eval (
    .board  (snap_board_reg),
    .owners (snap_owner_reg),
    .mask   (cur_mask),
    .hit    (line_hit),
    .owner  (line_owner)
  );

  // State register
  always_ff @(posedge clk) begin
    if (reset) state_reg <= IDLE;
    else       state_reg <= state_next;
  end

  // Next-state logic
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (start) state_next = SCAN;
      SCAN:    if (line_hit || scan_last) state_next = RESULT;
      RESULT:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Status outputs decoded from the state
  always_comb begin
    busy = (state_reg == SCAN);
    done = (state_reg == RESULT);
  end

  // Snapshot, scan index and result registers
  always_ff @(posedge clk) begin
    if (reset) begin
      idx_reg        <= 4'd0;
      snap_board_reg <= 16'h0000;
      snap_owner_reg <= 16'h0000;
      winner_reg     <= P_NONE;
      draw_reg       <= 1'b0;
    end else if (start) begin
      idx_reg        <= 4'd0;
      snap_board_reg <= gameboard;
      snap_owner_reg <= players_cells;
      winner_reg     <= P_NONE;
      draw_reg       <= 1'b0;
    end else if (state_reg == SCAN) begin
      if (line_hit) begin
        winner_reg <= line_owner;
      end else if (scan_last) begin
        draw_reg <= (snap_board_reg == 16'hFFFF);
      end else begin
        idx_reg <= idx_reg + 4'd1;
      end
    end
  end

`ifdef WIN_LINE_EN
  logic [15:0] win_line_reg;

  // Winning-cell mask, captured alongside the winner
  always_ff @(posedge clk) begin
    if (reset) begin
      win_line_reg <= 16'h0000;
    end else if (start) begin
      win_line_reg <= 16'h0000;
    end else if ((state_reg == SCAN) && line_hit) begin
      win_line_reg <= cur_mask;
    end
  end

  assign win_line = win_line_reg;
`else
  assign win_line = 16'h0000;
`endif

  // Result outputs; game_over follows the registered result
  always_comb begin
    winner    = winner_reg;
    draw      = draw_reg;
    game_over = (winner_reg != P_NONE) || draw_reg;
  end

endmodule
